// File: rtl/z80_rom_fetch_bridge.sv
// Z80 bus to SDRAM ROM port bridge: turns in-window CPU reads into 16-bit word requests,
// stalls the CPU through WAIT_n until data returns, and keeps a one-word line buffer.
module z80_rom_fetch_bridge #(
  parameter int unsigned    AW         = 22,
  parameter logic [AW-1:0]  ROM_OFFSET = '0,
  parameter logic [15:0]    WIN_LO     = 16'h0000,
  parameter logic [15:0]    WIN_HI     = 16'hBFFF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [15:0]   A,
  input  logic          MREQ_n,
  input  logic          RD_n,
  input  logic          RFSH_n,
  output logic          WAIT_n,
  output logic [7:0]    DOUT,
  output logic          SEL,
  input  logic          rom_flush,
  output logic [AW-1:0] rom_addr,
  output logic          rom_req,
  input  logic          rom_ack,
  input  logic [15:0]   rom_data
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StHold
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;
  logic [14:0]   tag_q, tag_d;
  logic [14:0]   req_tag_q, req_tag_d;
  logic [15:0]   word_q, word_d;
  logic [7:0]    dout_q, dout_d;

  logic          in_win;
  logic          rd_active;
  logic          hit;
  logic [14:0]   word_idx;
  logic [AW-1:0] addr_calc;

  // Signed 32-bit compare keeps the window check free of constant-bound lint noise.
  assign in_win    = (int'(A) >= int'(WIN_LO)) && (int'(A) <= int'(WIN_HI));
  assign rd_active = ~MREQ_n & ~RD_n & RFSH_n & in_win;
  assign hit       = valid_q & (tag_q == A[15:1]);

  assign word_idx  = A[15:1] - WIN_LO[15:1];
  assign addr_calc = ROM_OFFSET + AW'(word_idx);

  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic odd);
    return odd ? w[15:8] : w[7:0];
  endfunction

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    req_tag_d = req_tag_q;
    word_d    = word_q;
    dout_d    = dout_q;

    if (rom_flush) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (rd_active) begin
          if (hit) begin
            dout_d  = pick_byte(word_q, A[0]);
            state_d = StHold;
          end else begin
            addr_d    = addr_calc;
            req_tag_d = A[15:1];
            req_d     = 1'b1;
            state_d   = StReq;
          end
        end
      end

      StReq: begin
        if (rom_ack) begin
          // Fill overrides a same-cycle flush.
          word_d  = rom_data;
          tag_d   = req_tag_q;
          valid_d = 1'b1;
          req_d   = 1'b0;
          // A new cycle to another word after an abort must not get this word's byte;
          // returning to idle re-issues it as a miss with WAIT_n still low.
          if (rd_active && (A[15:1] == req_tag_q)) begin
            dout_d  = pick_byte(rom_data, A[0]);
            state_d = StHold;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StHold: begin
        if (!rd_active) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      tag_q     <= '0;
      req_tag_q <= '0;
      word_q    <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      req_tag_q <= req_tag_d;
      word_q    <= word_d;
      dout_q    <= dout_d;
    end
  end

  // Combinational so the stall is visible before the CPU samples WAIT_n in T2.
  assign WAIT_n   = ~(((state_q == StIdle) & rd_active & ~hit) |
                      ((state_q == StReq) & rd_active));
  assign DOUT     = dout_q;
  assign SEL      = rd_active;
  assign rom_addr = addr_q;
  assign rom_req  = req_q;

endmodule

// File: tb/tb_z80_rom_fetch_bridge.sv
// Directed self-checking bench for z80_rom_fetch_bridge.
module tb_z80_rom_fetch_bridge;

  localparam int unsigned AW = 22;
  localparam logic [AW-1:0] Offset = 22'h000100;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [15:0]   A;
  logic          MREQ_n, RD_n, RFSH_n;
  logic          WAIT_n;
  logic [7:0]    DOUT;
  logic          SEL;
  logic          rom_flush;
  logic [AW-1:0] rom_addr;
  logic          rom_req;
  logic          rom_ack;
  logic [15:0]   rom_data;

  int n_cmp = 0;
  int n_err = 0;

  z80_rom_fetch_bridge #(
    .AW        (AW),
    .ROM_OFFSET(Offset),
    .WIN_LO    (16'h0000),
    .WIN_HI    (16'hBFFF)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .A        (A),
    .MREQ_n   (MREQ_n),
    .RD_n     (RD_n),
    .RFSH_n   (RFSH_n),
    .WAIT_n   (WAIT_n),
    .DOUT     (DOUT),
    .SEL      (SEL),
    .rom_flush(rom_flush),
    .rom_addr (rom_addr),
    .rom_req  (rom_req),
    .rom_ack  (rom_ack),
    .rom_data (rom_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_read(input logic [15:0] addr);
    A = addr; MREQ_n = 1'b0; RD_n = 1'b0; RFSH_n = 1'b1;
    #1;
  endtask

  task automatic bus_idle();
    MREQ_n = 1'b1; RD_n = 1'b1; RFSH_n = 1'b1;
    #1;
  endtask

  initial begin
    RESET = 1'b1; A = '0; MREQ_n = 1'b1; RD_n = 1'b1; RFSH_n = 1'b1;
    rom_flush = 1'b0; rom_ack = 1'b0; rom_data = '0;
    tick(); tick();
    RESET = 1'b0;
    check("rst_wait", 32'(WAIT_n), 32'h1);
    check("rst_sel", 32'(SEL), 32'h0);
    check("rst_dout", 32'(DOUT), 32'h0);
    check("rst_req", 32'(rom_req), 32'h0);
    check("rst_addr", 32'(rom_addr), 32'h0);

    // Miss at 0x0000, ack 5 clocks after request
    bus_read(16'h0000);
    check("miss_sel", 32'(SEL), 32'h1);
    check("miss_wait_comb", 32'(WAIT_n), 32'h0);
    check("miss_req_pre", 32'(rom_req), 32'h0);
    tick();
    check("miss_req", 32'(rom_req), 32'h1);
    check("miss_addr", 32'(rom_addr), 32'h100);
    for (int i = 0; i < 4; i++) begin
      check("miss_wait_held", 32'({WAIT_n, rom_req}), 32'h1);
      tick();
    end
    rom_ack = 1'b1; rom_data = 16'hA53C;
    #1;
    check("miss_wait_ackclk", 32'(WAIT_n), 32'h0);
    tick();
    rom_ack = 1'b0;
    check("miss_dout", 32'(DOUT), 32'h3C);
    check("miss_wait_rise", 32'(WAIT_n), 32'h1);
    check("miss_req_drop", 32'(rom_req), 32'h0);
    bus_idle(); tick();
    check("miss_end_sel", 32'(SEL), 32'h0);

    // Hit at 0x0001
    bus_read(16'h0001);
    check("hit_wait", 32'(WAIT_n), 32'h1);
    tick();
    check("hit_dout", 32'(DOUT), 32'hA5);
    check("hit_req", 32'(rom_req), 32'h0);
    check("hit_wait_after", 32'(WAIT_n), 32'h1);
    bus_idle(); tick();

    // Ignored cycles: refresh, write, out-of-window read
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin A = 16'h0002; MREQ_n = 1'b0; RD_n = 1'b0; RFSH_n = 1'b0; end
        1: begin A = 16'h0002; MREQ_n = 1'b0; RD_n = 1'b1; RFSH_n = 1'b1; end
        default: begin A = 16'hC000; MREQ_n = 1'b0; RD_n = 1'b0; RFSH_n = 1'b1; end
      endcase
      #1;
      check("ign_wait", 32'(WAIT_n), 32'h1);
      check("ign_sel", 32'(SEL), 32'h0);
      tick();
      check("ign_req", 32'(rom_req), 32'h0);
      check("ign_dout", 32'(DOUT), 32'hA5);
      bus_idle(); tick();
    end

    // Aborted miss at 0x0010; fill still lands, 0x0011 then hits
    bus_read(16'h0010);
    tick();
    check("abort_req", 32'(rom_req), 32'h1);
    check("abort_addr", 32'(rom_addr), 32'h108);
    bus_idle();
    check("abort_wait", 32'(WAIT_n), 32'h1);
    tick(); tick();
    check("abort_req_held", 32'(rom_req), 32'h1);
    rom_ack = 1'b1; rom_data = 16'h7E81;
    tick();
    rom_ack = 1'b0;
    check("abort_req_drop", 32'(rom_req), 32'h0);
    check("abort_dout_kept", 32'(DOUT), 32'hA5);
    bus_read(16'h0011);
    check("abort_hit_wait", 32'(WAIT_n), 32'h1);
    tick();
    check("abort_hit_dout", 32'(DOUT), 32'h7E);
    check("abort_hit_req", 32'(rom_req), 32'h0);
    bus_idle(); tick();

    // Refill 0x0000, flush, then 0x0001 must miss
    bus_read(16'h0000);
    tick();
    rom_ack = 1'b1; rom_data = 16'hA53C;
    tick();
    rom_ack = 1'b0;
    check("refill_dout", 32'(DOUT), 32'h3C);
    bus_idle(); tick();
    rom_flush = 1'b1; tick(); rom_flush = 1'b0;
    bus_read(16'h0001);
    check("flush_wait", 32'(WAIT_n), 32'h0);
    tick();
    check("flush_req", 32'(rom_req), 32'h1);
    check("flush_addr", 32'(rom_addr), 32'h100);

    // Flush coinciding with ack: fill wins
    rom_ack = 1'b1; rom_data = 16'h5AC3; rom_flush = 1'b1;
    tick();
    rom_ack = 1'b0; rom_flush = 1'b0;
    check("fa_dout", 32'(DOUT), 32'h5A);
    check("fa_wait", 32'(WAIT_n), 32'h1);
    bus_idle(); tick();
    bus_read(16'h0000);
    check("fa_valid_wait", 32'(WAIT_n), 32'h1);
    tick();
    check("fa_hit_dout", 32'(DOUT), 32'hC3);
    check("fa_hit_req", 32'(rom_req), 32'h0);
    bus_idle(); tick();

    // Reset mid-REQ, then a late ack
    bus_read(16'h0020);
    tick();
    check("rr_req", 32'(rom_req), 32'h1);
    check("rr_addr", 32'(rom_addr), 32'h110);
    RESET = 1'b1; bus_idle();
    tick();
    RESET = 1'b0;
    check("rr_req_drop", 32'(rom_req), 32'h0);
    check("rr_addr_clr", 32'(rom_addr), 32'h0);
    check("rr_dout_clr", 32'(DOUT), 32'h0);
    check("rr_wait", 32'(WAIT_n), 32'h1);
    check("rr_sel", 32'(SEL), 32'h0);
    tick();
    rom_ack = 1'b1; rom_data = 16'hFFFF;
    tick();
    rom_ack = 1'b0;
    check("rr_late_dout", 32'(DOUT), 32'h0);
    check("rr_late_req", 32'(rom_req), 32'h0);
    bus_read(16'h0000);
    check("rr_invalid_wait", 32'(WAIT_n), 32'h0);
    tick();
    check("rr_invalid_req", 32'(rom_req), 32'h1);
    rom_ack = 1'b1; rom_data = 16'h1234;
    tick();
    rom_ack = 1'b0;
    check("rr_final_dout", 32'(DOUT), 32'h34);
    bus_idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/z80_rom_fetch_bridge.md
# z80_rom_fetch_bridge

Bus-side consumer of the Z80 core wrapper's memory cycles. It sits between the CPU bus (A, MREQ_n, RD_n, RFSH_n) and the shared SDRAM ROM port. It turns in-window CPU reads into 16-bit SDRAM word requests and stretches the cycle through WAIT_n until data returns. A one-word line buffer serves sequential byte fetches from the same word with zero wait states.

## Interface
Parameters:
- AW, 22, SDRAM word-address width.
- ROM_OFFSET, 0, SDRAM word address that CPU address WIN_LO maps to.
- WIN_LO, 16'h0000, lowest CPU byte address served (inclusive).
- WIN_HI, 16'hBFFF, highest CPU byte address served (inclusive).

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock, same clock as the CPU wrapper.
- RESET  in  1  synchronous, active-high reset.
- A  in  16  CPU address bus.
- MREQ_n  in  1  CPU memory request.
- RD_n  in  1  CPU read strobe.
- RFSH_n  in  1  CPU refresh indicator.
- WAIT_n  out  1  to CPU WAIT_n; low stalls the CPU in T2.
- DOUT  out  8  byte for the CPU DI mux.
- SEL  out  1  high while this block owns DI (rd_active).
- rom_flush  in  1  one-clock pulse that invalidates the line buffer.
- rom_addr  out  AW  SDRAM word address.
- rom_req  out  1  level request, held until ack.
- rom_ack  in  1  one-clock pulse; rom_data is valid in the same clock.
- rom_data  in  16  SDRAM word; bits [7:0] = even byte, bits [15:8] = odd byte.

## Operation
- rd_active = ~MREQ_n & ~RD_n & RFSH_n & (WIN_LO <= A <= WIN_HI). This signal is combinational.
- Word index = A[15:1] - WIN_LO[15:1]. rom_addr = ROM_OFFSET + word index, truncated to AW bits.
- Line buffer contents: tag (15 bits), valid bit, 16-bit word. hit = valid & (tag == A[15:1]).
- State IDLE:
  - On rd_active & hit: DOUT = buffer byte selected by A[0]; go to HOLD.
  - On rd_active & ~hit: latch rom_addr, set rom_req = 1, go to REQ.
- State REQ:
  - Wait for rom_ack.
  - On ack: buffer word = rom_data, tag = A[15:1] latched at request, valid = 1, rom_req = 0.
  - If rd_active is still high: DOUT = selected byte, go to HOLD. Otherwise (aborted cycle) go to IDLE.
- State HOLD: DOUT is held. When rd_active falls, go to IDLE.
- WAIT_n = ~((state == IDLE & rd_active & ~hit) | (state == REQ & rd_active)). It is combinational so it is valid before the T2 CEN_n sample.
- Writes, IO cycles, refresh cycles and out-of-window addresses are ignored. These cycles never touch the buffer or WAIT_n.
- rom_flush clears valid in any state. If it coincides with a REQ ack, the ack fill wins (valid = 1).
- An rom_ack received outside REQ is ignored.

## Timing
- Reset values: state IDLE, rom_req 0, rom_addr 0, valid 0, tag 0, DOUT 8'h00, WAIT_n 1, SEL 0.
- Reset mid-REQ: rom_req drops the next clock, and a late ack is discarded.
- Miss latency: rom_req rises 1 CLK after rd_active is first seen. DOUT is valid and WAIT_n rises in the same clock edge as rom_ack, plus 0 CLK of combinational delay.
- Hit latency: DOUT is valid 1 CLK after rd_active; WAIT_n never falls.
- The CPU's CEN spacing must be ≥ 2 CLK so that the registered DOUT settles before the T3 DI sample.
- rom_req is level-held for the whole REQ state and does not drop before ack (no abort toward SDRAM).
- Back-to-back reads: at least one clock of IDLE separates HOLD from the next request.

## Test plan
- Miss: read 0x0000 with rom_ack 5 CLK after req and rom_data 16'hA53C -> rom_addr = ROM_OFFSET, WAIT_n low for the 5 clocks, DOUT = 8'h3C, WAIT_n high on the ack clock.
- Hit: next read at 0x0001 -> no rom_req, WAIT_n stays 1, DOUT = 8'hA5 after 1 CLK.
- Ignore: refresh cycle (RFSH_n = 0) at 0x0002, a write at 0x0002, and a read at 0xC000 -> rom_req stays 0, WAIT_n stays 1, SEL stays 0.
- Abort: read 0x0010 miss, then deassert MREQ_n before ack -> rom_req is held until ack, state returns to IDLE, and a following read at 0x0011 is a hit.
- Flush: rom_flush after the fill at 0x0000, then read 0x0001 -> a new rom_req is issued.
- Flush coinciding with ack -> buffer stays valid.
- Reset mid-REQ: assert RESET during REQ -> all outputs return to reset values next CLK, and an ack 2 CLK later leaves valid = 0 and DOUT = 8'h00.
